wb_single_master: RTL and testbench

Single-access Wishbone classic initiator: the bus-master counterpart to the multi-project harness's Wishbone responder. It accepts one read/write command at a time on a valid/ready command port and runs exactly one classic cycle (cyc/stb held until ack). It returns read data or a timeout error on a valid/ready response port. It sits between bring-up/test logic (LA-driven sequencer, UART bridge) and any Wishbone slave in the user area.

---
 rtl/wb_single_master_pkg.sv | 25 ++
 rtl/wb_single_master.sv | 168 ++++++++++++++++
 tb/tb_wb_single_master.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_single_master_pkg.sv
// wb_single_master_pkg
// Shared definitions for the single-access Wishbone classic initiator:
//   - state_e      : FSM state encoding (IDLE=0, BUS=1, RESP=2)
//   - ADR_*        : base addresses of the harness responder's address map
//   - illegal_cmd  : a write with no byte lanes enabled is rejected
//                    without ever starting a bus cycle
package wb_single_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Harness responder address map
    localparam logic [31:0] ADR_SELECT = 32'h3000_0000;
    localparam logic [31:0] ADR_WS2812 = 32'h3000_0100;
    localparam logic [31:0] ADR_7SEG   = 32'h3000_0200;
    localparam logic [31:0] ADR_FREQ   = 32'h3000_0400;

    function automatic logic illegal_cmd(input logic we, input logic [3:0] sel);
        return we && (sel == 4'b0000);
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// wb_single_master
// Single-access Wishbone classic initiator. Accepts one command at a time on
// a valid/ready command port, runs exactly one classic cycle (cyc/stb held
// until ack or timeout) and returns the result on a valid/ready response port.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_we/sel/adr/dat command fields
//   rsp_valid/rsp_ready   response handshake; rsp_dat (read data, 0 for
//                         writes/errors), rsp_err (timeout or illegal command)
//   wbm_*                 Wishbone classic master signals
//   busy                  high whenever the FSM is not in IDLE
//
// Every output is a flop; cmd_ready and rsp_valid are decoded from the next
// state so neither ever depends combinationally on the other side's inputs.
module wb_single_master
    import wb_single_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    // Abort happens on the edge that ends the TIMEOUT-th BUS cycle, i.e.
    // when the counter (cleared on entry) already holds TIMEOUT-1.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (illegal_cmd(cmd_we, cmd_sel)) begin
                        // Rejected without touching the bus
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                        rsp_dat_d = '0;
                    end else begin
                        state_d = ST_BUS;
                        cnt_d   = '0;
                        cyc_d   = 1'b1;
                        we_d    = cmd_we;
                        sel_d   = cmd_sel;
                        adr_d   = cmd_adr;
                        dat_d   = cmd_dat;
                    end
                end
            end

            ST_BUS: begin
                // Ack is tested first so it wins over a simultaneous timeout
                if (wbm_ack_i || (cnt_q == TIMEOUT_LAST)) begin
                    state_d   = ST_RESP;
                    rsp_err_d = !wbm_ack_i;
                    rsp_dat_d = (wbm_ack_i && !we_q) ? wbm_dat_i : '0;
                    cnt_d     = '0;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = '0;
                    adr_d     = '0;
                    dat_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d   = ST_IDLE;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_single_master.sv
// tb_wb_single_master
// Drives wb_single_master against a registered-ack model slave whose latency
// is chosen per access. The slave acknowledges after it has sampled cyc/stb
// high on `slave_lat` edges, so an acked access keeps cyc high slave_lat+1
// cycles; addresses with adr[11:8]==4'hF are unmapped and never acked.
// The reference model predicts response data/error and cyc duration from
// the access rules alone, using a plain word array as memory.
module tb_wb_single_master;
    import wb_single_master_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    wb_single_master #(.TIMEOUT(TO), .TW(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic unmapped(input logic [31:0] a);
        return a[11:8] == 4'hF;
    endfunction

    // ---------------- model slave ----------------
    int          slave_lat = 1;
    int          seen;
    logic        mem_clear = 1'b1;
    logic [31:0] smem [0:1023];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) smem[i] <= '0;
            seen      <= 0;
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= '0;
        end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
            seen <= seen + 1;
            if ((seen + 1 >= slave_lat) && !unmapped(wbm_adr_o)) begin
                wbm_ack_i <= 1'b1;
                if (wbm_we_o)
                    smem[wbm_adr_o[11:2]] <= merge(smem[wbm_adr_o[11:2]], wbm_dat_o, wbm_sel_o);
                else
                    wbm_dat_i <= smem[wbm_adr_o[11:2]];
            end
        end else begin
            seen      <= 0;
            wbm_ack_i <= 1'b0;
        end
    end

    // ---------------- bus monitor: gaps between cycles, acks per cycle ----------------
    initial begin
        int   gap;
        int   run_acks;
        logic prev_cyc;
        logic have_run;
        gap = 0; run_acks = 0; prev_cyc = 1'b0; have_run = 1'b0;
        forever begin
            @(negedge clk);
            if (wbm_cyc_o) begin
                if (!prev_cyc && have_run) chk("cyc_gap_ge2", 64'(gap >= 2), 64'(1));
                if (wbm_ack_i) run_acks++;
            end else begin
                if (prev_cyc) begin
                    chk("acks_per_cycle_le1", 64'(run_acks <= 1), 64'(1));
                    run_acks = 0;
                    have_run = 1'b1;
                    gap = 0;
                end
                gap++;
            end
            prev_cyc = wbm_cyc_o;
        end
    end

    // ---------------- reference model memory ----------------
    logic [31:0] ref_mem [0:1023];

    task automatic do_access(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                             input logic [31:0] dat, input int lat, input int hold);
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_cyc;
        int          cyc_n;
        int          n;
        logic        bad;
        logic [31:0] held_dat;
        logic        held_err;

        // Reference model
        if (we && sel == 4'b0000) begin
            exp_err = 1'b1; exp_dat = '0; exp_cyc = 0;
        end else if (unmapped(adr) || (lat + 1 > TO)) begin
            exp_err = 1'b1; exp_dat = '0; exp_cyc = TO;
        end else begin
            exp_err = 1'b0; exp_cyc = lat + 1;
            if (we) begin
                ref_mem[adr[11:2]] = merge(ref_mem[adr[11:2]], dat, sel);
                exp_dat = '0;
            end else begin
                exp_dat = ref_mem[adr[11:2]];
            end
        end

        slave_lat = lat;
        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;

        cyc_n = 0; bad = 1'b0; n = 0;
        while (!rsp_valid && n < TO + 8) begin
            if (wbm_cyc_o) begin
                cyc_n++;
                if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_sel_o !== sel ||
                    wbm_adr_o !== adr || wbm_dat_o !== dat || cmd_ready !== 1'b0)
                    bad = 1'b1;
            end else begin
                bad = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        chk("rsp_arrives", 64'(rsp_valid), 64'(1));
        chk("cyc_cycles", 64'(cyc_n), 64'(exp_cyc));
        chk("bus_fields_stable", 64'(bad), 64'(0));

        held_dat = rsp_dat; held_err = rsp_err; bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== held_dat || rsp_err !== held_err ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
                bad = 1'b1;
        end
        if (hold > 0) chk("rsp_held_stable", 64'(bad), 64'(0));
        chk("rsp_dat", 64'(rsp_dat), 64'(exp_dat));
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        $display("txn we=%0d sel=%h adr=%h dat=%h lat=%0d hold=%0d -> rsp_dat=%h rsp_err=%0d cyc=%0d",
                 we, sel, adr, dat, lat, hold, rsp_dat, rsp_err, cyc_n);

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_idle_flags", 64'({rsp_valid, busy, cmd_ready, wbm_cyc_o}), 64'(4'b0010));
        chk("post_idle_zero", 64'({rsp_err, rsp_dat, wbm_we_o, wbm_sel_o, wbm_stb_o}), 64'(0));
    endtask

    initial begin
        int   n_rsp, n_ack, n_err, n;
        logic bad;

        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_dat, busy}), 64'(0));
        chk("rst_wbm_ctl", 64'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 64'(0));
        chk("rst_wbm_adr", 64'(wbm_adr_o), 64'(0));
        chk("rst_wbm_dat", 64'(wbm_dat_o), 64'(0));
        reset = 1'b0; mem_clear = 1'b0;

        // Directed: write/read select register, timeout, held response, ack==timeout edge
        do_access(1'b1, 4'hF, ADR_SELECT, 32'h0000_0003, 1, 0);
        do_access(1'b0, 4'hF, ADR_SELECT, 32'h0, 1, 0);
        do_access(1'b0, 4'hF, 32'h3000_0F00, 32'h0, 1, 0);
        do_access(1'b1, 4'h3, ADR_WS2812, 32'hDEAD_BEEF, 2, 0);
        do_access(1'b0, 4'hF, ADR_WS2812, 32'h0, 3, 5);
        do_access(1'b0, 4'hF, ADR_SELECT, 32'h0, TO - 1, 0);
        do_access(1'b0, 4'hF, ADR_SELECT, 32'h0, TO, 2);
        do_access(1'b1, 4'h0, ADR_SELECT, 32'hFFFF_FFFF, 1, 0);

        // Reset on the 3rd BUS cycle of a slow access
        slave_lat = 10;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = ADR_FREQ;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_flags", 64'({cmd_ready, wbm_cyc_o, wbm_stb_o, busy, rsp_valid}), 64'(5'b10000));
        chk("rst_mid_adr", 64'(wbm_adr_o), 64'(0));
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) bad = 1'b1;
        end
        chk("rst_no_rsp", 64'(bad), 64'(0));
        do_access(1'b1, 4'hF, ADR_FREQ, 32'h1234_5678, 1, 0);
        do_access(1'b0, 4'hF, ADR_FREQ, 32'h0, 2, 0);

        // Back-to-back writes with cmd_valid held high and rsp_ready tied high
        slave_lat = 1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = ADR_7SEG; cmd_dat = 32'h0000_00A5;
        rsp_ready = 1'b1;
        n_rsp = 0; n_ack = 0; n_err = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin n_rsp++; if (rsp_err) n_err++; end
            if (wbm_ack_i && wbm_cyc_o) n_ack++;
        end
        cmd_valid = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            if (rsp_valid) begin n_rsp++; if (rsp_err) n_err++; end
            if (wbm_ack_i && wbm_cyc_o) n_ack++;
            n++;
        end
        rsp_ready = 1'b0;
        ref_mem[ADR_7SEG[11:2]] = 32'h0000_00A5;
        chk("b2b_drained", 64'(busy), 64'(0));
        chk("b2b_rsp_eq_ack", 64'(n_rsp), 64'(n_ack));
        chk("b2b_min_rsp", 64'(n_rsp >= 5), 64'(1));
        chk("b2b_no_err", 64'(n_err), 64'(0));
        $display("txn b2b writes: responses=%0d acks=%0d errors=%0d", n_rsp, n_ack, n_err);
        do_access(1'b0, 4'hF, ADR_7SEG, 32'h0, 1, 0);

        // Randomized accesses
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            a = {20'h30000, 4'($urandom_range(0, 15)), 6'($urandom), 2'b00};
            do_access(1'($urandom), 4'($urandom), a, $urandom, int'($urandom_range(1, TO - 1)),
                      int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
